// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and frame constants, common to
// the transmitter and the receiver.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int DATA_BITS            = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each
// period. restart holds the count at zero so the next period begins cleanly.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_end = (cnt == LAST) && !restart;

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter, 8-N-1 by default, 8-E-1 when UART_TX_PARITY_EN is defined.
// Bytes are accepted on a valid/ready handshake and shifted out LSB first.
//
//   state  | meaning
//   IDLE   | line high, ready for a byte
//   START  | start bit (line low)
//   DATA   | data bits 0..7, LSB first
//   PARITY | even parity bit (parity build only)
//   STOP   | stop bit (line high), tx_done on exit
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       uart_txd,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_e state;
    logic [7:0]  shift_reg;
    logic [2:0]  bit_index;
    logic        bit_end;
`ifdef UART_TX_PARITY_EN
    logic        parity_bit;
`endif

    assign tx_ready = (state == IDLE) && rst_n;
    assign tx_busy  = (state != IDLE);

    // Held in restart while idle so START gets a full period from the accept edge.
    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (state == IDLE),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            uart_txd  <= 1'b1;
            tx_done   <= 1'b0;
            shift_reg <= '0;
            bit_index <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    uart_txd <= 1'b1;
                    if (tx_valid) begin
                        shift_reg <= tx_data;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^tx_data;
`endif
                        uart_txd  <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_index <= '0;
                        uart_txd  <= shift_reg[0];
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_reg <= shift_reg >> 1;
                        if (bit_index == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            uart_txd <= parity_bit;
                            state    <= PARITY;
`else
                            uart_txd <= 1'b1;
                            state    <= STOP;
`endif
                        end else begin
                            bit_index <= bit_index + 3'd1;
                            uart_txd  <= shift_reg[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        uart_txd <= 1'b1;
                        state    <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        uart_txd <= 1'b1;
                        tx_done  <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    uart_txd <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: reset, single frames, parity pattern,
// back-to-back handshake, mid-frame reset and a mid-bit sampling loopback at 434.
module tb_uart_transmitter;
    import uart_pkg::*;

    localparam int C  = 4;
    localparam int CL = DEFAULT_CLKS_PER_BIT;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, uart_txd, tx_busy, tx_done;

    logic       tx_valid_l = 1'b0;
    logic [7:0] tx_data_l = 8'h00;
    logic       tx_ready_l, uart_txd_l, tx_busy_l, tx_done_l;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    uart_transmitter #(.CLKS_PER_BIT(C)) u_dut (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .uart_txd(uart_txd), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    uart_transmitter #(.CLKS_PER_BIT(CL)) u_dut_loop (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid_l), .tx_data(tx_data_l),
        .tx_ready(tx_ready_l), .uart_txd(uart_txd_l), .tx_busy(tx_busy_l), .tx_done(tx_done_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line levels of one frame, bit 0 first on the line.
    function automatic logic [10:0] frame_bits(input logic [7:0] b);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^b;
`endif
        return f;
    endfunction

    // Entered just after the accept edge; returns the cycle where the stop bit began.
    task automatic check_frame(input logic [7:0] b, input string tag, output int stop_cyc);
        logic [10:0] f;
        int          start_cyc;
        f = frame_bits(b);
        start_cyc = cyc;
        stop_cyc = 0;
        for (int i = 0; i < NB * C; i++) begin
            @(negedge clk);
            chk({tag, ":line"}, uart_txd, f[i / C]);
            chk({tag, ":done_low"}, tx_done, 1'b0);
            if (i == 0) begin
                chk({tag, ":busy"}, tx_busy, 1'b1);
                chk({tag, ":ready_busy"}, tx_ready, 1'b0);
            end
            if (i == (NB - 1) * C) stop_cyc = cyc;
        end
        @(negedge clk);
        chk({tag, ":done"}, tx_done, 1'b1);
        chk({tag, ":ready_idle"}, tx_ready, 1'b1);
        chk({tag, ":busy_idle"}, tx_busy, 1'b0);
        chk({tag, ":idle_line"}, uart_txd, 1'b1);
        chk({tag, ":frame_len"}, cyc - start_cyc, NB * C);
    endtask

    task automatic send_one(input logic [7:0] b, input string tag);
        int stop_c;
        tx_valid = 1'b1;
        tx_data  = b;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = ~b;
        check_frame(b, tag, stop_c);
        @(negedge clk);
        chk({tag, ":done_pulse"}, tx_done, 1'b0);
    endtask

    task automatic loop_byte(input logic [7:0] b, input string tag);
        logic [7:0] rx;
        logic       seen;
        rx = 8'h00;
        @(negedge clk);
        tx_valid_l = 1'b1;
        tx_data_l  = b;
        @(posedge clk);
        #1;
        tx_valid_l = 1'b0;
        tx_data_l  = ~b;
        repeat (CL / 2 + 1) @(negedge clk);
        chk({tag, ":start"}, uart_txd_l, 1'b0);
        for (int k = 0; k < 8; k++) begin
            repeat (CL) @(negedge clk);
            rx[k] = uart_txd_l;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CL) @(negedge clk);
        chk({tag, ":parity"}, uart_txd_l, ^b);
`endif
        repeat (CL) @(negedge clk);
        chk({tag, ":stop"}, uart_txd_l, 1'b1);
        chk({tag, ":data"}, rx, b);
        seen = 1'b0;
        for (int w = 0; w < CL && !seen; w++) begin
            @(negedge clk);
            if (tx_done_l) seen = 1'b1;
        end
        chk({tag, ":done_seen"}, seen, 1'b1);
    endtask

    initial begin
        int stop1, stop2;

        // Reset held with a byte offered: nothing may leave.
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        repeat (3) begin
            @(negedge clk);
            chk("rst:line", uart_txd, 1'b1);
            chk("rst:ready", tx_ready, 1'b0);
            chk("rst:busy", tx_busy, 1'b0);
            chk("rst:done", tx_done, 1'b0);
        end
        rst_n    = 1'b1;
        tx_valid = 1'b0;
        @(negedge clk);
        chk("post_rst:ready", tx_ready, 1'b1);
        chk("post_rst:line", uart_txd, 1'b1);

        send_one(8'h55, "b55");
        send_one(8'h07, "b07");
        send_one(8'h03, "b03");
        send_one(8'h81, "b81");

        // Back-to-back with tx_valid held; tx_data moves on right after the first accept.
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        @(posedge clk);
        #1;
        tx_data = 8'h3C;
        check_frame(8'hA5, "btb1", stop1);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        chk("btb:start_after_stop", cyc - stop1, C + 1);
        check_frame(8'h3C, "btb2", stop2);
        @(negedge clk);

        // Reset while DATA bit 3 is on the line.
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        repeat (4 * C + 2) @(negedge clk);
        chk("mid:bit3", uart_txd, 1'b1);
        chk("mid:busy_before", tx_busy, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid:line", uart_txd, 1'b1);
        chk("mid:busy", tx_busy, 1'b0);
        chk("mid:ready", tx_ready, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 12 * C; i++) begin
            @(negedge clk);
            chk("mid:no_done", tx_done, 1'b0);
            chk("mid:idle_line", uart_txd, 1'b1);
        end
        send_one(8'hFF, "bFF");

        loop_byte(8'h00, "lb00");
        loop_byte(8'hFF, "lbFF");
        loop_byte(8'h5A, "lb5A");
        loop_byte(8'h81, "lb81");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
